vedacao_consumo_rolhas: RTL and testbench
=========================================

Name: vedacao_consumo_rolhas

Overview:
Consumer end of the cork path. It tracks the corks available at the sealing head and removes one cork per sealed bottle. It requests a refill from the dispenser side when the count is low, and absorbs refill transfers with a request/grant handshake. It runs the seal cycle for each bottle (gar/pos) and raises alarme when a bottle arrives with no cork available.

Parameters:
WIDTH, 8, width of the cork counter and of the refill quantity
LIMIAR, 5, low-stock threshold: refill is requested while count <= LIMIAR
TEMPO_VEDA, 3, number of cycles ve is held high per bottle (>=1)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
gar  input  1  bottle present at station
pos  input  1  bottle in sealing position
reabastece  input  1  one-cycle grant from dispenser; qtd_refill valid this cycle
qtd_refill  input  WIDTH  corks delivered with the grant
pede_rolha  output  1  refill request, registered, held until grant
rolha_disponivel  output  WIDTH  current cork count, registered
rolha_baixa  output  1  combinational: rolha_disponivel <= LIMIAR
ve  output  1  seal actuator, registered (Moore)
done  output  1  one-cycle pulse, bottle sealed
alarme  output  1  bottle waiting with zero corks
garrafas_vedadas  output  16  sealed-bottle count (optional feature)

Behaviour:
- Reset (async, active-high): count=0, state=IDLE, seal timer=0; pede_rolha, ve, done, alarme, garrafas_vedadas all 0. ve drops immediately, including mid-seal.
- Counter update each edge: next = count + (reabastece ? qtd_refill : 0) - (consume ? 1 : 0).
  - Compute in WIDTH+1 bits.
  - Saturate at 2^WIDTH-1; excess corks are discarded.
  - Refill and consume in the same cycle both apply.
  - Underflow is impossible by construction: consume happens only when count > 0.
- pede_rolha:
  - Set on the edge where count <= LIMIAR and no grant is present.
  - Cleared on the edge where reabastece=1.
  - First assertion is on the first edge after reset release (count=0).
  - A grant arriving while pede_rolha=0 is still accepted and added.
- FSM states:
  - IDLE: gar=1 & count>0 -> ESPERA_POS; gar=1 & count=0 -> ALARME.
  - ESPERA_POS: gar=0 -> IDLE; pos=1 -> VEDANDO, with consume=1 on this transition edge.
  - VEDANDO: ve=1. Timer counts TEMPO_VEDA cycles, then -> CONCLUI. gar/pos are ignored during the seal.
  - CONCLUI: done=1 for one cycle, garrafas_vedadas increments, -> SAIDA.
  - SAIDA: wait for gar=0 -> IDLE. This prevents double sealing of the same bottle.
  - ALARME: alarme=1. count>0 -> ESPERA_POS (gar still 1) or IDLE (gar=0); gar=0 alone -> IDLE.
- Latency: pos sampled high at edge N -> ve=1 in cycles N+1..N+TEMPO_VEDA, done in cycle N+TEMPO_VEDA+1, count reduced from cycle N+1.
- Refill visibility: a grant at edge N is visible in rolha_disponivel at N+1. ALARME is left at edge N+1.

Optional Feature:
CONTADOR_GARRAFAS_EN.
- Defined: garrafas_vedadas is a 16-bit register, reset 0, +1 per done pulse, wraps 65535 -> 0.
- Undefined: no counter logic is built; the garrafas_vedadas port remains and is tied to 0.

Test Plan:
- Reset then idle 3 cycles -> rolha_disponivel=0, rolha_baixa=1, pede_rolha=1 from the first edge after reset release. Grant with qtd_refill=10 -> count=10, pede_rolha=0, rolha_baixa=0.
- count=10, gar=1, pos=1 at edge N (TEMPO_VEDA=3) -> ve high for cycles N+1..N+3, done in cycle N+4, count=9. Holding gar=1 through SAIDA causes no second seal.
- count=0, gar=1 -> alarme=1. Grant with qtd_refill=4 -> count=4 next cycle, alarme=0, seal proceeds when pos=1 -> count=3.
- count=6, seal consumes to 5 -> rolha_baixa=1 and pede_rolha=1 next edge. Grant qtd_refill=7 on the same edge as the next consume -> count=5+7-1=11.
- count=250, grant qtd_refill=20 -> count saturates at 255. Reset asserted mid-VEDANDO -> ve=0 and count=0 immediately.
- With CONTADOR_GARRAFAS_EN defined, 3 bottles sealed -> garrafas_vedadas=3. Without the macro -> garrafas_vedadas stays 0.

Source files
------------

// File: rtl/vedacao_consumo_rolhas.sv
// Cork consumer at the sealing head: cork stock, refill handshake and per-bottle seal cycle.
// Optional CONTADOR_GARRAFAS_EN builds the 16-bit sealed-bottle counter; otherwise it is tied to 0.
module vedacao_consumo_rolhas #(
  parameter int WIDTH      = 8,
  parameter int LIMIAR     = 5,
  parameter int TEMPO_VEDA = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gar,
  input  logic             pos,
  input  logic             reabastece,
  input  logic [WIDTH-1:0] qtd_refill,
  output logic             pede_rolha,
  output logic [WIDTH-1:0] rolha_disponivel,
  output logic             rolha_baixa,
  output logic             ve,
  output logic             done,
  output logic             alarme,
  output logic [15:0]      garrafas_vedadas
);

  localparam int TW = (TEMPO_VEDA > 1) ? $clog2(TEMPO_VEDA) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(TEMPO_VEDA - 1);
  localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIAR);
  localparam logic [WIDTH:0]   MAXV   = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    IDLE, ESPERA_POS, VEDANDO, CONCLUI, SAIDA, ALARME
  } estado_t;

  estado_t          estado;
  logic [TW-1:0]    timer;
  logic [WIDTH:0]   soma;
  logic [WIDTH-1:0] cnt_nxt;
  logic             consume;
  logic             vazio;
  logic             fim_veda;

  assign vazio    = (rolha_disponivel == '0);
  assign consume  = (estado == ESPERA_POS) && gar && pos && !vazio;
  assign fim_veda = (estado == VEDANDO) && (timer == T_LAST);

  // Sum in WIDTH+1 bits so refill overflow is visible before saturating.
  always_comb begin
    soma = {1'b0, rolha_disponivel}
         + (reabastece ? {1'b0, qtd_refill} : '0)
         - {{WIDTH{1'b0}}, consume};
    cnt_nxt = (soma > MAXV) ? {WIDTH{1'b1}} : soma[WIDTH-1:0];
  end

  assign rolha_baixa = (rolha_disponivel <= LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rolha_disponivel <= '0;
      pede_rolha       <= 1'b0;
    end else begin
      rolha_disponivel <= cnt_nxt;
      if (reabastece)       pede_rolha <= 1'b0;
      else if (rolha_baixa) pede_rolha <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      timer  <= '0;
      ve     <= 1'b0;
      done   <= 1'b0;
      alarme <= 1'b0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (gar && !vazio) estado <= ESPERA_POS;
          else if (gar) begin
            estado <= ALARME;
            alarme <= 1'b1;
          end
        end
        ESPERA_POS: begin
          if (!gar) estado <= IDLE;
          else if (consume) begin
            estado <= VEDANDO;
            timer  <= '0;
            ve     <= 1'b1;
          end
        end
        VEDANDO: begin
          // gar/pos deliberately ignored until the seal completes
          if (fim_veda) begin
            estado <= CONCLUI;
            ve     <= 1'b0;
            done   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CONCLUI: estado <= SAIDA;
        SAIDA:   if (!gar) estado <= IDLE;
        ALARME: begin
          if (!vazio) begin
            estado <= gar ? ESPERA_POS : IDLE;
            alarme <= 1'b0;
          end else if (!gar) begin
            estado <= IDLE;
            alarme <= 1'b0;
          end
        end
        default: begin
          estado <= IDLE;
          ve     <= 1'b0;
          alarme <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONTADOR_GARRAFAS_EN
  // Counts on the edge that raises done, so the count and the pulse appear together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         garrafas_vedadas <= '0;
    else if (fim_veda) garrafas_vedadas <= garrafas_vedadas + 16'd1;
  end
`else
  assign garrafas_vedadas = '0;
`endif

endmodule

// File: tb/tb_vedacao_consumo_rolhas.sv
// Directed cycle table plus hand sequences for async reset mid-seal and the bottle counter.
module tb_vedacao_consumo_rolhas;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gar = 1'b0, pos = 1'b0, reabastece = 1'b0;
  logic [7:0] qtd_refill = '0;
  logic       pede_rolha, rolha_baixa, ve, done, alarme;
  logic [7:0] rolha_disponivel;
  logic [15:0] garrafas_vedadas;

  int n_pass = 0;
  int n_tot  = 0;

  vedacao_consumo_rolhas #(.WIDTH(8), .LIMIAR(5), .TEMPO_VEDA(3)) dut (
    .clk(clk), .reset(reset), .gar(gar), .pos(pos),
    .reabastece(reabastece), .qtd_refill(qtd_refill),
    .pede_rolha(pede_rolha), .rolha_disponivel(rolha_disponivel),
    .rolha_baixa(rolha_baixa), .ve(ve), .done(done), .alarme(alarme),
    .garrafas_vedadas(garrafas_vedadas)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, rb;
    logic [7:0] qtd;
    logic       gar, pos;
    logic [7:0] cnt;
    logic       pede, baixa, ve, done, alarme;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic rb, logic [7:0] qtd, logic g, logic p,
                              logic [7:0] cnt, logic pede, logic baixa, logic v,
                              logic d, logic a);
    vec_t r;
    r.rst = rst; r.rb = rb; r.qtd = qtd; r.gar = g; r.pos = p;
    r.cnt = cnt; r.pede = pede; r.baixa = baixa; r.ve = v; r.done = d; r.alarme = a;
    return r;
  endfunction

  task automatic chk(string nome, logic [12:0] got, logic [12:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got cnt=%0d pede=%b baixa=%b ve=%b done=%b alarme=%b, want cnt=%0d pede=%b baixa=%b ve=%b done=%b alarme=%b",
                  nome, got[12:5], got[4], got[3], got[2], got[1], got[0],
                  want[12:5], want[4], want[3], want[2], want[1], want[0]);
  endtask

  task automatic chk16(string nome, logic [15:0] got, logic [15:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nome, got, want);
  endtask

  function automatic logic [12:0] obs();
    return {rolha_disponivel, pede_rolha, rolha_baixa, ve, done, alarme};
  endfunction

  logic [15:0] exp_garr;

  initial begin
    //                  rst rb qtd  g  p   cnt pd bx ve dn al
    // idle after reset, then grant of 10
    tv.push_back(mk(0, 0,   0, 0, 0,   0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   0, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 1,  10, 0, 0,  10, 0, 0, 0, 0, 0));
    // one bottle, gar held through SAIDA: single seal
    tv.push_back(mk(0, 0,   0, 1, 0,  10, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   9, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   9, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   9, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   9, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   9, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   9, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   9, 0, 0, 0, 0, 0));
    // synchronous-looking reset, then bottle with no corks -> alarm
    tv.push_back(mk(1, 0,   0, 0, 0,   0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 0,   0, 1, 1, 0, 0, 1));
    tv.push_back(mk(0, 1,   4, 1, 0,   4, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0,   0, 1, 0,   4, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   3, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 0,   3, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   3, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   3, 1, 1, 0, 1, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   3, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   3, 1, 1, 0, 0, 0));
    // stock 6, seal to 5 -> low stock and request on the following edge
    tv.push_back(mk(0, 1,   3, 0, 0,   6, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 0,   6, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 1,   5, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 0,   5, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 1, 0,   5, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   5, 1, 1, 0, 1, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   5, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,   5, 1, 1, 0, 0, 0));
    // grant of 7 on the same edge as a consume: 5+7-1
    tv.push_back(mk(0, 0,   0, 1, 0,   5, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 1,   7, 1, 1,  11, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,  11, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,  11, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,  11, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,  11, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0,   0, 0, 0,  11, 0, 0, 0, 0, 0));
    // saturation at 255
    tv.push_back(mk(0, 1, 239, 0, 0, 250, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1,  20, 0, 0, 255, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 200, 0, 0, 255, 0, 0, 0, 0, 0));

    // reset state before any edge
    @(negedge clk);
    chk("reset_state", obs(), {8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk16("reset_garrafas", garrafas_vedadas, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; reabastece = tv[i].rb; qtd_refill = tv[i].qtd;
      gar = tv[i].gar; pos = tv[i].pos;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), obs(),
          {tv[i].cnt, tv[i].pede, tv[i].baixa, tv[i].ve, tv[i].done, tv[i].alarme});
      @(negedge clk);
    end
    reset = 1'b0; reabastece = 1'b0; qtd_refill = '0; gar = 1'b0; pos = 1'b0;

    // three bottles sealed since the in-table reset
`ifdef CONTADOR_GARRAFAS_EN
    exp_garr = 16'd3;
`else
    exp_garr = 16'd0;
`endif
    chk16("garrafas_after_3", garrafas_vedadas, exp_garr);

    // async reset in the middle of a seal
    gar = 1'b1;
    @(posedge clk); @(negedge clk);
    pos = 1'b1;
    @(posedge clk); #1;
    chk("seal_start", obs(), {8'd254, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_mid_seal", obs(), {8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk16("async_reset_garrafas", garrafas_vedadas, 16'd0);
    @(negedge clk);
    reset = 1'b0; gar = 1'b0; pos = 1'b0;
    @(posedge clk); #1;
    chk("after_release", obs(), {8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
